// File: rtl/fetch_pc_sequencer_if.sv
// Fetch-side bundle: branch predictor lookup, I-cache request/response port
// and fetch queue push port, as seen by fetch_pc_sequencer.
interface fetch_pc_sequencer_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] pc;
    logic             predTaken;
    logic [WIDTH-1:0] predTarget;
    logic             redirectValid;
    logic [WIDTH-1:0] redirectPc;
    logic             icReqValid;
    logic [WIDTH-1:0] icReqPc;
    logic             icReqReady;
    logic             icRespValid;
    logic             fqFull;
    logic             fqPushValid;
    logic [WIDTH-1:0] fqPushPc;
    logic             fqPushPredTaken;
    logic [WIDTH-1:0] fqPushTarget;

    modport master (
        output pc, icReqValid, icReqPc, fqPushValid, fqPushPc, fqPushPredTaken, fqPushTarget,
        input  predTaken, predTarget, redirectValid, redirectPc, icReqReady, icRespValid, fqFull
    );

    modport slave (
        input  pc, icReqValid, icReqPc, fqPushValid, fqPushPc, fqPushPredTaken, fqPushTarget,
        output predTaken, predTarget, redirectValid, redirectPc, icReqReady, icRespValid, fqFull
    );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Front-end fetch PC owner: one outstanding I-cache block request, redirect > predicted > sequential.
// Optional: define FETCH_REDIRECT_BYPASS_EN to forward a redirect straight onto the request port in IDLE/REQ.
module fetch_pc_sequencer #(
    parameter int               WIDTH       = 64,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(64'h0000_0000_8000_0000),
    parameter int               FETCH_BYTES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clkEn,
    fetch_pc_sequencer_if.master  bus
);

    localparam logic [WIDTH-1:0] BLOCK_MASK = ~(WIDTH'(FETCH_BYTES - 1));
    localparam logic [WIDTH-1:0] BLOCK_STEP = WIDTH'(FETCH_BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] req_pc_q, req_pc_d;
    logic             pred_q, pred_d;
    logic [WIDTH-1:0] target_q, target_d;

    logic             req_valid;
    logic [WIDTH-1:0] req_addr;
    logic             req_pred;
    logic [WIDTH-1:0] req_target;
    logic             push_valid;
    logic [WIDTH-1:0] redirect_pc;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        pred_d      = pred_q;
        target_d    = target_q;
        req_valid   = 1'b0;
        req_addr    = pc_q & BLOCK_MASK;
        req_pred    = bus.predTaken;
        req_target  = bus.predTarget;
        push_valid  = 1'b0;
        redirect_pc = bus.redirectPc & ~WIDTH'(1);

        unique case (state_q)
            S_IDLE, S_REQ: begin
                if (clkEn) state_d = S_REQ;
`ifdef FETCH_REDIRECT_BYPASS_EN
                if (bus.redirectValid) begin
                    req_addr   = bus.redirectPc & BLOCK_MASK;
                    req_pred   = 1'b0;
                    req_target = '0;
                    req_valid  = clkEn && !bus.fqFull;
                end else begin
                    req_valid  = clkEn && !bus.fqFull && (state_q == S_REQ);
                end
`else
                // A redirect costs one bubble: the request waits for the new pc.
                req_valid = clkEn && !bus.fqFull && !bus.redirectValid && (state_q == S_REQ);
`endif
            end
            S_WAIT: begin
                if (clkEn && bus.icRespValid) begin
                    push_valid = !bus.redirectValid;
                    state_d    = S_REQ;
                end else if (clkEn && bus.redirectValid) begin
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (clkEn && bus.icRespValid) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase

        if (req_valid && bus.icReqReady) begin
            req_pc_d = req_addr;
            pred_d   = req_pred;
            target_d = req_target;
            pc_d     = req_pred ? req_target : req_addr + BLOCK_STEP;
            state_d  = S_WAIT;
        end else if (clkEn && bus.redirectValid) begin
            pc_d     = redirect_pc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            pred_q   <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            pred_q   <= pred_d;
            target_q <= target_d;
        end
    end

    assign bus.pc              = pc_q;
    assign bus.icReqValid      = req_valid;
    assign bus.icReqPc         = req_addr;
    assign bus.fqPushValid     = push_valid;
    assign bus.fqPushPc        = req_pc_q;
    assign bus.fqPushPredTaken = pred_q;
    assign bus.fqPushTarget    = target_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed, table-driven bench for fetch_pc_sequencer; FETCH_REDIRECT_BYPASS_EN selects
// the expected timing of the redirect-forwarding sequence.
module tb_fetch_pc_sequencer;

    typedef struct packed {
        logic        req_v;
        logic [63:0] req_pc;
        logic        push_v;
        logic [63:0] push_pc;
        logic        push_pt;
        logic [63:0] push_tgt;
        logic [63:0] pc;
    } obs_t;

    typedef struct {
        logic        en, rdy, resp, full, pt;
        logic [63:0] ptgt;
        logic        rv;
        logic [63:0] rpc;
        obs_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clk_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    fetch_pc_sequencer_if #(.WIDTH(64)) bus ();

    fetch_pc_sequencer #(
        .WIDTH      (64),
        .RESET_PC   (64'h0000_0000_8000_0000),
        .FETCH_BYTES(16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .clkEn(clk_en),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, rdy, resp, full, pt, input logic [63:0] ptgt,
                                input logic rv, input logic [63:0] rpc,
                                input logic ev, input logic [63:0] erpc, input logic epv,
                                input logic [63:0] eppc, input logic eppt, input logic [63:0] eptgt,
                                input logic [63:0] epc);
        vec_t v;
        v.en = en; v.rdy = rdy; v.resp = resp; v.full = full; v.pt = pt; v.ptgt = ptgt;
        v.rv = rv; v.rpc = rpc;
        v.exp = '{ev, erpc, epv, eppc, eppt, eptgt, epc};
        return v;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = '{bus.icReqValid, bus.icReqPc, bus.fqPushValid, bus.fqPushPc,
              bus.fqPushPredTaken, bus.fqPushTarget, bus.pc};
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got reqV=%b reqPc=%h pushV=%b pushPc=%h pushPt=%b pushTgt=%h pc=%h ; want reqV=%b reqPc=%h pushV=%b pushPc=%h pushPt=%b pushTgt=%h pc=%h",
                     name, act.req_v, act.req_pc, act.push_v, act.push_pc, act.push_pt, act.push_tgt, act.pc,
                     exp.req_v, exp.req_pc, exp.push_v, exp.push_pc, exp.push_pt, exp.push_tgt, exp.pc);
        end
    endtask

    task automatic drive(input vec_t v);
        clk_en            = v.en;
        bus.icReqReady    = v.rdy;
        bus.icRespValid   = v.resp;
        bus.fqFull        = v.full;
        bus.predTaken     = v.pt;
        bus.predTarget    = v.ptgt;
        bus.redirectValid = v.rv;
        bus.redirectPc    = v.rpc;
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        #1;
        check(name, sample(), v.exp);
    endtask

    localparam logic [63:0] FFF0 = 64'hFFFF_FFFF_FFFF_FFF0;

    initial begin
        // Sequential fetch, one-cycle response, no prediction.
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 0,64'h8000_0000,0,0,0,0,64'h8000_0000));
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 1,64'h8000_0000,0,0,0,0,64'h8000_0000));
        vecs.push_back(mk(1,1,1,0,0,0,0,0, 0,64'h8000_0010,1,64'h8000_0000,0,0,64'h8000_0010));
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 1,64'h8000_0010,0,64'h8000_0000,0,0,64'h8000_0010));
        vecs.push_back(mk(1,1,1,0,0,0,0,0, 0,64'h8000_0020,1,64'h8000_0010,0,0,64'h8000_0020));
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 1,64'h8000_0020,0,64'h8000_0010,0,0,64'h8000_0020));
        vecs.push_back(mk(1,1,1,0,0,0,0,0, 0,64'h8000_0030,1,64'h8000_0020,0,0,64'h8000_0030));
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 1,64'h8000_0030,0,64'h8000_0020,0,0,64'h8000_0030));
        vecs.push_back(mk(1,1,1,0,0,0,0,0, 0,64'h8000_0040,1,64'h8000_0030,0,0,64'h8000_0040));
        // Predicted taken at 0x8000_0040 to 0x8000_1008.
        vecs.push_back(mk(1,1,0,0,1,64'h8000_1008,0,0, 1,64'h8000_0040,0,64'h8000_0030,0,0,64'h8000_0040));
        vecs.push_back(mk(1,1,1,0,0,0,0,0, 0,64'h8000_1000,1,64'h8000_0040,1,64'h8000_1008,64'h8000_1008));
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 1,64'h8000_1000,0,64'h8000_0040,1,64'h8000_1008,64'h8000_1008));
        // Redirect in WAIT, stale response two cycles later is dropped.
        vecs.push_back(mk(1,1,0,0,0,0,1,64'h2002, 0,64'h8000_1010,0,64'h8000_1000,0,0,64'h8000_1010));
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 0,64'h2000,0,64'h8000_1000,0,0,64'h2002));
        vecs.push_back(mk(1,1,1,0,0,0,0,0, 0,64'h2000,0,64'h8000_1000,0,0,64'h2002));
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 1,64'h2000,0,64'h8000_1000,0,0,64'h2002));
        vecs.push_back(mk(1,1,1,0,0,0,0,0, 0,64'h2010,1,64'h2000,0,0,64'h2010));
        // Fetch queue full for five cycles in REQ.
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1,1,0,1,0,0,0,0, 0,64'h2010,0,64'h2000,0,0,64'h2010));
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 1,64'h2010,0,64'h2000,0,0,64'h2010));
        vecs.push_back(mk(1,1,1,0,0,0,0,0, 0,64'h2020,1,64'h2010,0,0,64'h2020));
        // Redirect to top block (bit 0 cleared), then sequential wrap to 0.
        vecs.push_back(mk(1,1,0,0,0,0,1,64'hFFFF_FFFF_FFFF_FFF1, 0,64'h2020,0,64'h2010,0,0,64'h2020));
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 1,FFF0,0,64'h2010,0,0,FFF0));
        // Clock enable low for three cycles mid-WAIT; responses then are ignored.
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0,1,1,0,0,0,0,0, 0,64'h0,0,FFF0,0,0,64'h0));
        vecs.push_back(mk(1,1,1,0,0,0,0,0, 0,64'h0,1,FFF0,0,0,64'h0));
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 1,64'h0,0,FFF0,0,0,64'h0));
        // Redirect coinciding with the response, then back-to-back redirects.
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 0,64'h10,0,64'h0,0,0,64'h10));
        vecs.push_back(mk(1,1,1,0,0,0,1,64'h3000, 0,64'h10,0,64'h0,0,0,64'h10));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,64'h3000,0,64'h0,0,0,64'h3000));
        vecs.push_back(mk(1,0,0,0,0,0,1,64'h5000, 0,64'h3000,0,64'h0,0,0,64'h3000));
        vecs.push_back(mk(1,0,0,0,0,0,1,64'h6000, 0,64'h5000,0,64'h0,0,0,64'h5000));
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 1,64'h6000,0,64'h0,0,0,64'h6000));
        vecs.push_back(mk(1,1,1,0,0,0,0,0, 0,64'h6010,1,64'h6000,0,0,64'h6010));
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 0,64'h6010,0,64'h6000,0,0,64'h6010));

        drive(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        @(negedge clk);
        #1;
        check("reset", sample(), '{1'b0, 64'h8000_0000, 1'b0, 64'h0, 1'b0, 64'h0, 64'h8000_0000});
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // Redirect to 0x4000 while in REQ with the cache ready.
`ifdef FETCH_REDIRECT_BYPASS_EN
        apply(mk(1,1,0,0,0,0,1,64'h4000, 1,64'h4000,0,64'h6000,0,0,64'h6010), "bypass_same_cycle");
        apply(mk(1,1,1,0,0,0,0,0, 0,64'h4010,1,64'h4000,0,0,64'h4010), "bypass_push");
`else
        apply(mk(1,1,0,0,0,0,1,64'h4000, 0,64'h6010,0,64'h6000,0,0,64'h6010), "redirect_bubble");
        apply(mk(1,1,0,0,0,0,0,0, 1,64'h4000,0,64'h6000,0,0,64'h4000), "redirect_next_cycle");
        apply(mk(1,1,1,0,0,0,0,0, 0,64'h4010,1,64'h4000,0,0,64'h4010), "redirect_push");
`endif

        // Asynchronous reset while a request is outstanding.
        apply(mk(1,1,0,0,0,0,0,0, 1,64'h4010,0,64'h4000,0,0,64'h4010), "pre_reset_req");
        @(negedge clk);
        drive(mk(1,1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        #2 rst = 1'b0;
        #1;
        check("mid_reset", sample(), '{1'b0, 64'h8000_0000, 1'b0, 64'h0, 1'b0, 64'h0, 64'h8000_0000});
        @(negedge clk);
        drive(mk(1,1,1,0,0,0,0,0, 0,0,0,0,0,0,0));
        rst = 1'b1;
        #1;
        check("post_reset_idle", sample(), '{1'b0, 64'h8000_0000, 1'b0, 64'h0, 1'b0, 64'h0, 64'h8000_0000});
        apply(mk(1,0,0,0,0,0,0,0, 1,64'h8000_0000,0,0,0,0,64'h8000_0000), "post_reset_req");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
